// File: rtl/bcd_serial_adder_if.sv
// Handshake and operand/result bundle for the serial BCD adder.
// The design side uses the slave modport; a driver uses master.
interface bcd_serial_adder_if #(
    parameter int DIGITS = 4
);
    logic                  START;
    logic                  SUB;
    logic [4*DIGITS-1:0]   A;
    logic [4*DIGITS-1:0]   B;
    logic                  BUSY;
    logic                  DONE;
    logic [4*DIGITS-1:0]   SUM;
    logic                  COUT;
    logic                  ERR;

    modport master (
        output START, SUB, A, B,
        input  BUSY, DONE, SUM, COUT, ERR
    );

    modport slave (
        input  START, SUB, A, B,
        output BUSY, DONE, SUM, COUT, ERR
    );
endinterface

// File: rtl/bcd_serial_adder.sv
// Multi-digit BCD adder/subtractor, one digit per clock, LSD first.
// Subtract uses 9's complement of B with an initial carry of 1.
module bcd_serial_adder #(
    parameter int DIGITS = 4,
    parameter int CNT_W  = 3
) (
    input  logic                 CLK,
    input  logic                 nRST,
    bcd_serial_adder_if.slave    bus
);
    localparam int W = 4 * DIGITS;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     res_q, res_d;
    logic [W-1:0]     sum_q, sum_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             sub_q, sub_d;
    logic             carry_q, carry_d;
    logic             err_pend_q, err_pend_d;
    logic             cout_q, cout_d;
    logic             err_q, err_d;

    logic [3:0]       a_dig;
    logic [3:0]       b_dig;
    logic [3:0]       b_adj;
    logic [3:0]       dig;
    logic [4:0]       t;
    logic             c_next;
    logic [W-1:0]     res_nx;
    logic             in_bad;
    logic             load;

    // One decimal digit step on the low nibbles of the shifting operands
    always_comb begin
        a_dig  = a_q[3:0];
        b_dig  = b_q[3:0];
        b_adj  = sub_q ? (4'd9 - b_dig) : b_dig;
        t      = {1'b0, a_dig} + {1'b0, b_adj} + {4'd0, carry_q};
        dig    = t[3:0];
        c_next = 1'b0;
        if (t > 5'd9) begin
            dig    = 4'(t - 5'd10);
            c_next = 1'b1;
        end
        res_nx = (res_q >> 4) | (W'(dig) << (W - 4));
    end

    // Flag any non-decimal nibble on the incoming operands
    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.A[4*i +: 4] > 4'd9 || bus.B[4*i +: 4] > 4'd9) begin
                in_bad = 1'b1;
            end
        end
    end

    // Next-state, datapath loads and result publication
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        sum_d      = sum_q;
        idx_d      = idx_q;
        sub_d      = sub_q;
        carry_d    = carry_q;
        err_pend_d = err_pend_q;
        cout_d     = cout_q;
        err_d      = err_q;
        load       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    load    = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                carry_d = c_next;
                res_d   = res_nx;
                idx_d   = idx_q + CNT_W'(1);
                if (idx_q == LAST) begin
                    state_d = S_DONE;
                    sum_d   = err_pend_q ? '0 : res_nx;
                    cout_d  = err_pend_q ? 1'b0 : c_next;
                    err_d   = err_pend_q;
                end
            end
            S_DONE: begin
                if (bus.START) begin
                    load    = 1'b1;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            a_d        = bus.A;
            b_d        = bus.B;
            sub_d      = bus.SUB;
            carry_d    = bus.SUB;
            idx_d      = '0;
            res_d      = '0;
            err_pend_d = in_bad;
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            sum_q      <= '0;
            idx_q      <= '0;
            sub_q      <= 1'b0;
            carry_q    <= 1'b0;
            err_pend_q <= 1'b0;
            cout_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            sum_q      <= sum_d;
            idx_q      <= idx_d;
            sub_q      <= sub_d;
            carry_q    <= carry_d;
            err_pend_q <= err_pend_d;
            cout_q     <= cout_d;
            err_q      <= err_d;
        end
    end

    assign bus.BUSY = (state_q == S_RUN);
    assign bus.DONE = (state_q == S_DONE);
    assign bus.SUM  = sum_q;
    assign bus.COUT = cout_q;
    assign bus.ERR  = err_q;
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed bench for the serial BCD adder, DIGITS=4.
// Outputs are sampled 1ns after each rising edge.
module tb_bcd_serial_adder;
    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 CLK = ~CLK;

    bcd_serial_adder_if #(.DIGITS(4)) bus ();

    bcd_serial_adder #(
        .DIGITS(4),
        .CNT_W (3)
    ) dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus.slave)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic launch(input logic [15:0] a, input logic [15:0] b,
                          input logic sub);
        bus.A     = a;
        bus.B     = b;
        bus.SUB   = sub;
        bus.START = 1'b1;
        step();
        bus.START = 1'b0;
    endtask

    // Waits (bounded) for DONE; cyc counts edges since START was sampled
    task automatic wait_done(input int c0, output int cyc, output int busy);
        cyc  = c0;
        busy = 0;
        while (bus.DONE !== 1'b1 && cyc < 20) begin
            if (bus.BUSY === 1'b1) busy++;
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        bus.START = 1'b0;
        bus.SUB   = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        nRST      = 1'b0;
        step();
        step();
        n_cmp++;
        if ({bus.BUSY, bus.DONE, bus.SUM, bus.COUT, bus.ERR} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset got=%h exp=00000",
                     {bus.BUSY, bus.DONE, bus.SUM, bus.COUT, bus.ERR});
        end
        nRST = 1'b1;
        step();
    endtask

    task automatic test_add();
        logic [15:0] va [3] = '{16'h1234, 16'h9999, 16'h9999};
        logic [15:0] vb [3] = '{16'h5678, 16'h0001, 16'h9999};
        logic [15:0] es [3] = '{16'h6912, 16'h0000, 16'h9998};
        logic        ec [3] = '{1'b0, 1'b1, 1'b1};
        int cyc, busy;
        for (int i = 0; i < 3; i++) begin
            launch(va[i], vb[i], 1'b0);
            wait_done(1, cyc, busy);
            n_cmp++;
            if (cyc !== 5 || busy !== 4) begin
                n_fail++;
                $display("FAIL add_lat[%0d] got cyc=%0d busy=%0d exp cyc=5 busy=4",
                         i, cyc, busy);
            end
            n_cmp++;
            if ({bus.BUSY, bus.SUM, bus.COUT, bus.ERR} !== {1'b0, es[i], ec[i], 1'b0}) begin
                n_fail++;
                $display("FAIL add[%0d] got busy=%b sum=%h cout=%b err=%b exp sum=%h cout=%b",
                         i, bus.BUSY, bus.SUM, bus.COUT, bus.ERR, es[i], ec[i]);
            end
            step();
        end
    endtask

    task automatic test_sub();
        logic [15:0] va [3] = '{16'h0500, 16'h0123, 16'h0123};
        logic [15:0] vb [3] = '{16'h0123, 16'h0500, 16'h0123};
        logic [15:0] es [3] = '{16'h0377, 16'h9623, 16'h0000};
        logic        ec [3] = '{1'b1, 1'b0, 1'b1};
        int cyc, busy;
        for (int i = 0; i < 3; i++) begin
            launch(va[i], vb[i], 1'b1);
            wait_done(1, cyc, busy);
            n_cmp++;
            if (cyc !== 5 || busy !== 4) begin
                n_fail++;
                $display("FAIL sub_lat[%0d] got cyc=%0d busy=%0d exp cyc=5 busy=4",
                         i, cyc, busy);
            end
            n_cmp++;
            if ({bus.SUM, bus.COUT, bus.ERR} !== {es[i], ec[i], 1'b0}) begin
                n_fail++;
                $display("FAIL sub[%0d] got sum=%h cout=%b err=%b exp sum=%h cout=%b",
                         i, bus.SUM, bus.COUT, bus.ERR, es[i], ec[i]);
            end
            step();
        end
    endtask

    task automatic test_err();
        int cyc, busy;
        launch(16'h00A0, 16'h0001, 1'b0);
        wait_done(1, cyc, busy);
        n_cmp++;
        if (cyc !== 5 || busy !== 4) begin
            n_fail++;
            $display("FAIL err_lat got cyc=%0d busy=%0d exp cyc=5 busy=4", cyc, busy);
        end
        n_cmp++;
        if ({bus.SUM, bus.COUT, bus.ERR} !== {16'h0000, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL err got sum=%h cout=%b err=%b exp sum=0000 cout=0 err=1",
                     bus.SUM, bus.COUT, bus.ERR);
        end
        step();
        n_cmp++;
        if ({bus.DONE, bus.ERR} !== 2'b01) begin
            n_fail++;
            $display("FAIL err_hold got done=%b err=%b exp done=0 err=1",
                     bus.DONE, bus.ERR);
        end
        launch(16'h0001, 16'h0002, 1'b0);
        wait_done(1, cyc, busy);
        n_cmp++;
        if ({bus.DONE, bus.SUM, bus.COUT, bus.ERR} !== {1'b1, 16'h0003, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL err_clear got done=%b sum=%h cout=%b err=%b exp done=1 sum=0003 cout=0 err=0",
                     bus.DONE, bus.SUM, bus.COUT, bus.ERR);
        end
        step();
    endtask

    task automatic test_ignore_and_reset();
        int cyc, busy;
        launch(16'h1111, 16'h2222, 1'b0);
        step();
        bus.A     = 16'h4444;
        bus.B     = 16'h4444;
        bus.SUB   = 1'b1;
        bus.START = 1'b1;
        step();
        bus.START = 1'b0;
        wait_done(3, cyc, busy);
        n_cmp++;
        if (cyc !== 5 || busy !== 2) begin
            n_fail++;
            $display("FAIL ignore_lat got cyc=%0d busy=%0d exp cyc=5 busy=2", cyc, busy);
        end
        n_cmp++;
        if ({bus.SUM, bus.COUT, bus.ERR} !== {16'h3333, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL ignore got sum=%h cout=%b err=%b exp sum=3333 cout=0 err=0",
                     bus.SUM, bus.COUT, bus.ERR);
        end
        step();
        n_cmp++;
        if ({bus.BUSY, bus.DONE, bus.SUM} !== {2'b00, 16'h3333}) begin
            n_fail++;
            $display("FAIL hold got busy=%b done=%b sum=%h exp busy=0 done=0 sum=3333",
                     bus.BUSY, bus.DONE, bus.SUM);
        end
        launch(16'h0001, 16'h0001, 1'b0);
        step();
        step();
        nRST = 1'b0;
        step();
        n_cmp++;
        if ({bus.BUSY, bus.DONE, bus.SUM, bus.COUT, bus.ERR} !== 20'h0) begin
            n_fail++;
            $display("FAIL mid_reset got=%h exp=00000",
                     {bus.BUSY, bus.DONE, bus.SUM, bus.COUT, bus.ERR});
        end
        nRST = 1'b1;
        for (int i = 0; i < 6; i++) step();
        n_cmp++;
        if ({bus.BUSY, bus.DONE, bus.SUM} !== 18'h0) begin
            n_fail++;
            $display("FAIL post_reset got busy=%b done=%b sum=%h exp all zero",
                     bus.BUSY, bus.DONE, bus.SUM);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_done;
        bus.A     = 16'h0001;
        bus.B     = 16'h0001;
        bus.SUB   = 1'b0;
        bus.START = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            step();
            exp_done = (e % 5 == 0);
            n_cmp++;
            if ({bus.DONE, bus.BUSY} !== {exp_done, ~exp_done}) begin
                n_fail++;
                $display("FAIL b2b_edge%0d got done=%b busy=%b exp done=%b busy=%b",
                         e, bus.DONE, bus.BUSY, exp_done, ~exp_done);
            end
            if (exp_done) begin
                n_cmp++;
                if ({bus.SUM, bus.COUT, bus.ERR} !== {16'h0002, 1'b0, 1'b0}) begin
                    n_fail++;
                    $display("FAIL b2b_sum%0d got sum=%h cout=%b err=%b exp sum=0002",
                             e, bus.SUM, bus.COUT, bus.ERR);
                end
            end
        end
        bus.START = 1'b0;
        step();
        n_cmp++;
        if ({bus.BUSY, bus.DONE} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_stop got busy=%b done=%b exp 0 0", bus.BUSY, bus.DONE);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_err();
        test_ignore_and_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
